// File: rtl/equation1_generator_if.sv
// Operand stream from the equation1 generator to the display/VGA layer.
// One operand per transfer, tagged with its position in the x, y, z load order.
interface equation1_generator_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_index;
  logic       out_ready;

  modport master (output out_valid, output out_data, output out_index, input out_ready);
  modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface

// File: rtl/equation1_generator.sv
// Poses an equation1 puzzle: finds (x, y, z) with y/z + (x/z)^2 == target using an
// LFSR-driven search, falling back to (0, target, 1), then streams x, y, z out.
module equation1_generator #(
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned Z_BITS    = 2
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   start,
  input  logic [6:0]             target,
  input  logic                   seed_load,
  input  logic [7:0]             seed,
  equation1_generator_if.master  stream,
  output logic                   busy,
  output logic                   done,
  output logic                   fallback
);
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned TGT_W     = 7;
  localparam int unsigned K_W       = 3;
  localparam int unsigned TRY_W     = 8;
  localparam int unsigned CALC_W    = 16;
  localparam int unsigned TRY_LIMIT = MAX_TRIES + 1;

  typedef enum logic [2:0] {IDLE, PICK, CHECK, SEND_X, SEND_Y, SEND_Z, DONE} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   l, l_n;
  logic [TGT_W-1:0]    tgt, tgt_n;
  logic [K_W-1:0]      k, k_n;
  logic [DATA_W-1:0]   x, x_n, y, y_n, z, z_n;
  logic [TRY_W-1:0]    tries, tries_n;
  logic                fallback_n, busy_n, done_n, valid_n;
  logic [DATA_W-1:0]   data_n;
  logic [IDX_W-1:0]    index_n;
  logic [CALC_W-1:0]   q_c, x_c, y_c;

  // State, search registers and registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state            <= IDLE;
      l                <= 8'hA5;
      tgt              <= '0;
      k                <= '0;
      x                <= '0;
      y                <= '0;
      z                <= '0;
      tries            <= '0;
      fallback         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_index <= '0;
    end else begin
      state            <= state_n;
      l                <= l_n;
      tgt              <= tgt_n;
      k                <= k_n;
      x                <= x_n;
      y                <= y_n;
      z                <= z_n;
      tries            <= tries_n;
      fallback         <= fallback_n;
      busy             <= busy_n;
      done             <= done_n;
      stream.out_valid <= valid_n;
      stream.out_data  <= data_n;
      stream.out_index <= index_n;
    end
  end

  // Next-state, search arithmetic and next output values
  always_comb begin
    state_n    = state;
    l_n        = seed_load ? ((seed == 8'h00) ? 8'h01 : seed)
                           : {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    tgt_n      = tgt;
    k_n        = k;
    x_n        = x;
    y_n        = y;
    z_n        = z;
    tries_n    = tries;
    fallback_n = fallback;
    q_c        = CALC_W'(k) * CALC_W'(k);
    x_c        = CALC_W'(k) * CALC_W'(z);
    y_c        = (CALC_W'(tgt) - q_c) * CALC_W'(z);

    case (state)
      IDLE: begin
        if (start) begin
          tgt_n      = target;
          tries_n    = '0;
          fallback_n = 1'b0;
          if (MAX_TRIES == 32'd0) begin
            // No search budget: answer straight away with the trivial triple
            x_n        = '0;
            y_n        = DATA_W'(target);
            z_n        = DATA_W'(1);
            fallback_n = 1'b1;
            state_n    = SEND_X;
          end else begin
            state_n = PICK;
          end
        end
      end
      PICK: begin
        z_n     = DATA_W'(l[Z_BITS-1:0]) + DATA_W'(1);
        k_n     = l[6:4];
        state_n = CHECK;
      end
      CHECK: begin
        // y wraps when q > tgt, so the q test must gate the other two
        if (q_c <= CALC_W'(tgt) && x_c <= CALC_W'(255) && y_c <= CALC_W'(255)) begin
          x_n     = DATA_W'(x_c);
          y_n     = DATA_W'(y_c);
          state_n = SEND_X;
        end else if (32'(tries) + 32'd2 < TRY_LIMIT) begin
          tries_n = tries + TRY_W'(1);
          state_n = PICK;
        end else begin
          x_n        = '0;
          y_n        = DATA_W'(tgt);
          z_n        = DATA_W'(1);
          fallback_n = 1'b1;
          state_n    = SEND_X;
        end
      end
      SEND_X:  if (stream.out_ready) state_n = SEND_Y;
      SEND_Y:  if (stream.out_ready) state_n = SEND_Z;
      SEND_Z:  if (stream.out_ready) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    valid_n = 1'b0;
    data_n  = '0;
    index_n = '0;
    case (state_n)
      SEND_X: begin valid_n = 1'b1; data_n = x_n; index_n = IDX_W'(0); end
      SEND_Y: begin valid_n = 1'b1; data_n = y_n; index_n = IDX_W'(1); end
      SEND_Z: begin valid_n = 1'b1; data_n = z_n; index_n = IDX_W'(2); end
      default: ;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end
endmodule

// File: tb/tb_equation1_generator.sv
// Directed bench for equation1_generator: a fallback-only instance and a searching
// instance checked against a reference model of the LFSR-driven search.
module tb_equation1_generator;
  logic       Clock = 1'b0;
  logic       Resetn, start, start0, seed_load;
  logic [6:0] target;
  logic [7:0] seed;
  logic       busy8, done8, fb8, busy0, done0, fb0;
  logic [7:0] m_l;
  int         n_cmp = 0;
  int         n_bad = 0;

  equation1_generator_if if8();
  equation1_generator_if if0();

  equation1_generator #(.MAX_TRIES(8), .Z_BITS(2)) dut8 (
    .Clock(Clock), .Resetn(Resetn), .start(start), .target(target),
    .seed_load(seed_load), .seed(seed), .stream(if8),
    .busy(busy8), .done(done8), .fallback(fb8));

  equation1_generator #(.MAX_TRIES(0), .Z_BITS(2)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .start(start0), .target(target),
    .seed_load(seed_load), .seed(seed), .stream(if0),
    .busy(busy0), .done(done0), .fallback(fb0));

  always #5 Clock = ~Clock;

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR, tracking the generator's free-running register cycle by cycle
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn)        m_l <= 8'hA5;
    else if (seed_load) m_l <= (seed == 8'h00) ? 8'h01 : seed;
    else                m_l <= step(m_l);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Search model: attempt i sees the LFSR value two cycles after attempt i-1
  task automatic model(input int t, input logic [7:0] l1,
                       output int ex, output int ey, output int ez,
                       output int n, output bit fb);
    logic [7:0] v;
    int zz, kk, q, xx, yy;
    v = l1;
    for (int i = 0; i < 8; i++) begin
      zz = int'(v[1:0]) + 1;
      kk = int'(v[6:4]);
      q  = kk * kk;
      xx = kk * zz;
      yy = (t - q) * zz;
      if (q <= t && xx <= 255 && yy <= 255) begin
        ex = xx; ey = yy; ez = zz; n = i + 1; fb = 1'b0;
        return;
      end
      v = step(step(v));
    end
    ex = 0; ey = t; ez = 1; n = 8; fb = 1'b1;
  endtask

  task automatic load_seed(input logic [7:0] s);
    seed = s; seed_load = 1'b1;
    @(posedge Clock); #1;
    seed_load = 1'b0;
  endtask

  // One full triple on the searching instance, optional stall while y is offered
  task automatic do_triple(input int t, input int stall, output int rx, output int ry, output int rz);
    int ex, ey, ez, n, cnt, zd;
    bit fb;
    int want[3];
    int got[3];
    target = 7'(t); start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    model(t, m_l, ex, ey, ez, n, fb);
    chk("busy_after_start", int'(busy8), 1);
    cnt = 0;
    while (!if8.out_valid && cnt < 100) begin
      @(posedge Clock); #1;
      cnt++;
    end
    chk("first_valid_latency", cnt, 2 * n);
    want = '{ex, ey, ez};
    for (int i = 0; i < 3; i++) begin
      chk("valid", int'(if8.out_valid), 1);
      chk("index", int'(if8.out_index), i);
      chk("data", int'(if8.out_data), want[i]);
      got[i] = int'(if8.out_data);
      if (i == 1 && stall > 0) begin
        if8.out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(posedge Clock); #1;
          chk("stall_valid", int'(if8.out_valid), 1);
          chk("stall_index", int'(if8.out_index), 1);
          chk("stall_data", int'(if8.out_data), ey);
        end
        if8.out_ready = 1'b1;
      end
      @(posedge Clock); #1;
    end
    chk("done_pulse", int'(done8), 1);
    chk("valid_in_done", int'(if8.out_valid), 0);
    chk("busy_in_done", int'(busy8), 1);
    chk("fallback", int'(fb8), int'(fb));
    zd = (got[2] == 0) ? 1 : got[2];
    chk("z_range", int'(got[2] >= 1 && got[2] <= 4), 1);
    chk("x_multiple_of_z", got[0] % zd, 0);
    chk("equation_value", got[1] / zd + (got[0] / zd) * (got[0] / zd), t);
    @(posedge Clock); #1;
    chk("done_cleared", int'(done8), 0);
    chk("busy_cleared", int'(busy8), 0);
    rx = got[0]; ry = got[1]; rz = got[2];
  endtask

  typedef struct {
    int tgt;
    int stall_y;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   px[6], py[6], pz[6];
    int   rx, ry, rz, cnt, dones, xfers;
    bit   seen;

    Resetn = 1'b0; start = 1'b0; start0 = 1'b0; seed_load = 1'b0;
    seed = 8'h00; target = 7'd0;
    if8.out_ready = 1'b1; if0.out_ready = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_valid8", int'(if8.out_valid), 0);
    chk("rst_data8", int'(if8.out_data), 0);
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_done8", int'(done8), 0);
    chk("rst_fallback8", int'(fb8), 0);
    chk("rst_valid0", int'(if0.out_valid), 0);
    Resetn = 1'b1;
    @(posedge Clock); #1;

    // Zero search budget: fallback triple on the very next cycle
    target = 7'd37; start0 = 1'b1;
    @(posedge Clock); #1;
    start0 = 1'b0;
    chk("fb0_x_valid", int'(if0.out_valid), 1);
    chk("fb0_x_index", int'(if0.out_index), 0);
    chk("fb0_x_data", int'(if0.out_data), 0);
    chk("fb0_flag", int'(fb0), 1);
    @(posedge Clock); #1;
    chk("fb0_y_index", int'(if0.out_index), 1);
    chk("fb0_y_data", int'(if0.out_data), 37);
    @(posedge Clock); #1;
    chk("fb0_z_index", int'(if0.out_index), 2);
    chk("fb0_z_data", int'(if0.out_data), 1);
    @(posedge Clock); #1;
    chk("fb0_done", int'(done0), 1);
    chk("fb0_valid_off", int'(if0.out_valid), 0);
    @(posedge Clock); #1;
    chk("fb0_done_off", int'(done0), 0);
    chk("fb0_busy_off", int'(busy0), 0);
    chk("fb0_flag_held", int'(fb0), 1);

    // Seeded search over boundary targets, including a y stall; must replay identically
    vecs[0] = '{0, 0};
    vecs[1] = '{1, 0};
    vecs[2] = '{49, 5};
    vecs[3] = '{100, 0};
    vecs[4] = '{127, 0};
    vecs[5] = '{127, 2};
    load_seed(8'h3C);
    for (int i = 0; i < 6; i++) begin
      do_triple(vecs[i].tgt, vecs[i].stall_y, rx, ry, rz);
      px[i] = rx; py[i] = ry; pz[i] = rz;
    end
    load_seed(8'h3C);
    for (int i = 0; i < 6; i++) begin
      do_triple(vecs[i].tgt, vecs[i].stall_y, rx, ry, rz);
      chk("replay_x", rx, px[i]);
      chk("replay_y", ry, py[i]);
      chk("replay_z", rz, pz[i]);
    end

    // start held high throughout: one triple, one done
    target = 7'd50; start = 1'b1;
    @(posedge Clock); #1;
    dones = 0; xfers = 0; cnt = 0; seen = 1'b0;
    while (!seen && cnt < 100) begin
      if (if8.out_valid && if8.out_ready) xfers++;
      if (done8) begin
        dones++; seen = 1'b1; start = 1'b0;
      end else begin
        @(posedge Clock); #1;
        cnt++;
      end
    end
    @(posedge Clock); #1;
    chk("held_busy_after_done", int'(busy8), 0);
    for (int i = 0; i < 3; i++) begin
      if (done8) dones++;
      if (if8.out_valid) xfers++;
      @(posedge Clock); #1;
    end
    chk("held_done_count", dones, 1);
    chk("held_xfer_count", xfers, 3);

    // Reset while x is being offered
    if8.out_ready = 1'b0; target = 7'd20; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    cnt = 0;
    while (!if8.out_valid && cnt < 100) begin
      @(posedge Clock); #1;
      cnt++;
    end
    chk("hold_x_valid", int'(if8.out_valid), 1);
    #2 Resetn = 1'b0;
    #1;
    chk("async_rst_valid", int'(if8.out_valid), 0);
    chk("async_rst_busy", int'(busy8), 0);
    chk("async_rst_done", int'(done8), 0);
    chk("async_rst_fallback", int'(fb8), 0);
    @(posedge Clock); #1;
    Resetn = 1'b1; if8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      chk("post_rst_idle_busy", int'(busy8), 0);
      chk("post_rst_idle_valid", int'(if8.out_valid), 0);
    end

    // Zero seed becomes 1; long random-target run must keep tracking the model
    load_seed(8'h00);
    for (int i = 0; i < 1000; i++) begin
      do_triple(int'($urandom_range(0, 127)), 0, rx, ry, rz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/equation1_generator.md
Name: equation1_generator

Overview:
- Produces an operand triple (x, y, z) for the round's target answer such that the equation1 expression y/z + (x/z)^2, evaluated with 8-bit unsigned integer division, equals the target exactly.
- Sends the operands in the same order the player loads them (x, then y, then z) over a valid/ready stream to the display/VGA layer.
- Sits beside the equation1 checker: both are fed the same OngoingTimer value; the checker grades the player, this block poses the puzzle.

Parameters:
MAX_TRIES, 8, number of random candidate attempts before falling back; 0 forces immediate fallback.
Z_BITS, 2, z = lfsr[Z_BITS-1:0] + 1, giving a z range of 1..2^Z_BITS.

Ports:
Clock  input  1  system clock, rising edge.
Resetn  input  1  asynchronous, active-low reset.
start  input  1  request a new triple; sampled only in IDLE.
target  input  7  answer value (OngoingTimer), latched on accepted start.
seed_load  input  1  load seed into the LFSR this cycle; overrides stepping.
seed  input  8  LFSR seed; 8'h00 is replaced by 8'h01.
out_ready  input  1  consumer ready.
out_valid  output  1  operand on out_data is valid.
out_data  output  8  operand value.
out_index  output  2  0 = x, 1 = y, 2 = z.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the z transfer.
fallback  output  1  high from CHECK-fail exhaustion until the next accepted start.

Behaviour:
- Reset (async, Resetn = 0):
  - State goes to IDLE; LFSR = 8'hA5.
  - All outputs 0; internal tgt/x/y/z/try counter = 0.
- LFSR:
  - Steps every cycle: l <= {l[6:0], l[7]^l[5]^l[4]^l[3]}.
  - seed_load takes priority over stepping.
  - Never holds zero.
- IDLE:
  - On start = 1: tgt <= target, tries <= 0, fallback <= 0, go to PICK.
- PICK (1 cycle):
  - z <= l[Z_BITS-1:0] + 1.
  - k <= l[6:4] (0..7).
  - Go to CHECK.
- CHECK (1 cycle), with 9-bit-plus intermediates:
  - q = k*k; x = k*z; y = (tgt - q)*z.
  - Pass if q <= tgt AND x <= 255 AND y <= 255: register x, y, go to SEND_X.
  - Else, if tries + 1 < MAX_TRIES: tries++, go to PICK.
  - Else: x = 0, y = tgt, z = 1, fallback <= 1, go to SEND_X.
  - With MAX_TRIES = 0, the first CHECK always takes the fallback.
- SEND_X / SEND_Y / SEND_Z:
  - out_valid = 1; out_index = 0/1/2; out_data = x/y/z.
  - Data is stable while out_valid && !out_ready.
  - Advance only on out_valid && out_ready; a transfer is exactly one cycle per operand when ready is held high.
  - After the z transfer go to DONE.
- DONE (1 cycle): done = 1, out_valid = 0, then go to IDLE.
- start while busy is ignored and not queued.
- target changing after acceptance has no effect.
- Invariant on every emitted triple: z >= 1, and (y/z) + (x/z)*(x/z) == tgt in integer arithmetic. x is always a multiple of z, and y/z is exact.
- Latency from accepted start to the first out_valid:
  - 2*(n attempts) + 1 cycles on a random pass.
  - 2*MAX_TRIES + 1 cycles on fallback (1 cycle when MAX_TRIES = 0).
- Boundaries:
  - tgt = 0 passes only with k = 0, giving x = 0, y = 0.
  - tgt = 127 with z = 4 and small k overflows y and is retried.
  - Resetn low mid-transfer drops out_valid immediately; the next triple needs a new start.

Test Plan:
1. MAX_TRIES = 0, start with target = 37, out_ready = 1 -> x = 0, y = 37, z = 1 on consecutive cycles with index 0, 1, 2; fallback = 1; done pulses one cycle after z.
2. MAX_TRIES = 8, seed_load seed = 8'h3C, then start with targets 0, 1, 49, 100, 127 in turn -> each triple satisfies y/z + (x/z)^2 == target, z in 1..4, x % z == 0; the run repeats identically after reseeding.
3. Back-pressure: hold out_ready = 0 for 5 cycles during SEND_Y -> out_valid stays 1 with out_data and out_index = 1 unchanged; y is transferred exactly once when ready rises.
4. Assert start every cycle while busy -> exactly one triple and one done per accepted start; busy falls in the cycle after done.
5. Drop Resetn during SEND_X -> out_valid, busy, done and fallback go to 0 immediately, with no clock edge needed; after release the block sits in IDLE until start.
6. seed = 8'h00 -> LFSR holds 8'h01 and advances; no lock-up; 1000 random-target runs all satisfy the invariant.
